// File: rtl/mem_stage_param.sv
// Memory stage: combinational next-PC select plus a word-addressed data memory
// with configurable access latency, stall handshake and a sticky halt state.
module mem_stage_param #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int ALIGN = 1,
  parameter int LAT   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_zero,
  input  logic          i_ltz,
  input  logic          i_branch,
  input  logic          i_jump,
  input  logic [1:0]    i_branch_op,
  input  logic [DW-1:0] i_branch_addr,
  input  logic [DW-1:0] i_pc,
  input  logic          i_mem_read,
  input  logic          i_mem_write,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_write_data,
  input  logic          i_halt,
  output logic [DW-1:0] o_branch_or_pc,
  output logic [DW-1:0] o_read_data,
  output logic          o_stall,
  output logic          o_halted,
  output logic          o_mem_err
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HALTED} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_halt_seen, w_halt_seen_next;
  logic          w_complete, w_stall;
  logic          w_cond, w_taken;
  logic          w_misaligned, w_err;
  logic [AW-1:0] w_idx;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_read_data;
  logic          w_unused;

  always_comb begin
    w_cond = 1'b0;
    case (i_branch_op)
      2'b00: w_cond = i_zero;
      2'b01: w_cond = ~i_zero;
      2'b10: w_cond = i_ltz;
      2'b11: w_cond = ~i_ltz;
      default: w_cond = 1'b0;
    endcase
    w_taken = (i_branch & w_cond) | i_jump;
  end

  assign o_branch_or_pc = w_taken ? i_branch_addr : i_pc;

  generate
    if (ALIGN > 0) begin : g_align
      assign w_misaligned = |i_addr[ALIGN-1:0];
    end else begin : g_noalign
      assign w_misaligned = 1'b0;
    end
  endgenerate

  // Address bits above the index field are deliberately ignored.
  assign w_idx    = i_addr[AW+ALIGN-1:ALIGN];
  assign w_err    = w_misaligned | (i_mem_read & i_mem_write);
  assign w_unused = ^i_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_halt_seen <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_halt_seen <= w_halt_seen_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_cnt_next       = r_cnt;
    w_halt_seen_next = r_halt_seen;
    w_complete       = 1'b0;
    w_stall          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_halt) begin
          w_next = S_HALTED;
        end else if (i_mem_read | i_mem_write) begin
          if (LAT == 1) begin
            w_complete = 1'b1;
          end else begin
            w_stall          = 1'b1;
            w_cnt_next       = CW'(1);
            w_halt_seen_next = 1'b0;
            w_next           = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (i_halt) w_halt_seen_next = 1'b1;
        // A halt seen at any point of the access takes effect after completion.
        if (r_cnt == LAST) begin
          w_complete = 1'b1;
          w_cnt_next = '0;
          w_next     = (r_halt_seen | i_halt) ? S_HALTED : S_IDLE;
        end else begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_HALTED: begin
        w_next = S_HALTED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_read_data <= '0;
    end else if (w_complete && !w_err) begin
      if (i_mem_write) r_mem[w_idx] <= i_write_data;
      if (i_mem_read)  r_read_data  <= r_mem[w_idx];
    end
  end

  assign o_read_data = r_read_data;
  assign o_stall     = w_stall;
  assign o_halted    = (r_state == S_HALTED);
  assign o_mem_err   = w_complete & w_err;

endmodule

// File: doc/mem_stage_param.md
Name: mem_stage_param

Overview:
Parametrised memory-stage block for the multi-cycle pipeline. It resolves the branch/jump target and selects the next PC combinationally. It also fronts an internal word-addressed data memory with configurable access latency. The block drives a stall handshake back to the pipeline and enters a halted state on halt. Instantiated between execute and write-back; replaces the fixed 16-bit, single-cycle memory stage.

Parameters:
DW, 16, data/address/PC width in bits
DEPTH, 256, data memory depth in words (power of 2)
AW, 8, word-index width, = log2(DEPTH)
ALIGN, 1, low address bits dropped for word indexing (log2(DW/8))
LAT, 2, memory access latency in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
zero  in  1  ALU result == 0
ltz  in  1  ALU result < 0
branch  in  1  conditional branch instruction
jump  in  1  unconditional jump
branch_op  in  2  00 eqz, 01 nez, 10 ltz, 11 gez
branch_addr  in  DW  branch/jump target
pc  in  DW  sequential next PC
mem_read  in  1  load request
mem_write  in  1  store request
addr  in  DW  byte address (ALU result)
write_data  in  DW  store data
halt  in  1  halt request
branch_or_pc  out  DW  selected next PC
read_data  out  DW  registered load data
stall  out  1  pipeline must hold all inputs stable
halted  out  1  block halted, sticky until reset
mem_err  out  1  one-cycle error pulse

Behaviour:
- Branch logic is purely combinational and independent of FSM state.
  - cond: eqz=zero, nez=~zero, ltz=ltz, gez=~ltz.
  - taken = (branch & cond) | jump; branch_or_pc = taken ? branch_addr : pc.
- Word index idx = addr[AW+ALIGN-1:ALIGN]. Address bits above that index field are ignored.
- Error: addr[ALIGN-1:0] != 0 (misaligned) or mem_read & mem_write together. On error:
  - the store is suppressed and read_data is unchanged;
  - mem_err pulses in the completion cycle.
- FSM states: IDLE, BUSY, HALTED.
- IDLE
  - req = (mem_read | mem_write) & ~halt.
  - req & LAT==1: operation completes at this edge; stay IDLE; stall=0.
  - req & LAT>1: stall=1 combinationally; cnt<=1; go to BUSY.
  - halt=1: go to HALTED; any same-cycle request is ignored (no store, no read).
- BUSY
  - cnt increments each cycle.
  - stall=1 while cnt<LAT-1 and 0 when cnt==LAT-1; completion at that edge; then go to IDLE.
  - If halt was seen during BUSY, it is latched and the next state after completion is HALTED.
- Each access therefore occupies exactly LAT cycles, with stall high for the first LAT-1 of them.
- Completion:
  - store: mem[idx]<=write_data;
  - load: read_data<=mem[idx].
  - read_data holds its value until the next completed load.
- HALTED: halted=1, stall=0, no accesses, memory frozen. Exit only via reset.
- Reset (rst=0, async), mid-access included:
  - FSM=IDLE, cnt=0, read_data=0, halted=0, mem_err=0;
  - all memory words=0;
  - any in-flight store is discarded.
- Inputs are sampled at the completion edge and must be held stable while stall=1.

Test Plan:
- Branch mux, all ops: zero=1, branch=1, op=00, branch_addr=0x0040, pc=0x0012 -> 0x0040. op=01 -> 0x0012. ltz=1, op=10 -> 0x0040. op=11 -> 0x0012. jump=1 overrides all -> 0x0040.
- Store/load, LAT=2:
  - store 0xBEEF to addr 0x0010 -> stall=1 one cycle, mem[8]=0xBEEF.
  - load 0x0010 -> stall=1 one cycle, read_data=0xBEEF at completion edge.
- LAT=1 vs LAT=4: same store/load pair -> stall never asserted at LAT=1; stall high exactly 3 cycles per access at LAT=4.
- Errors: load addr 0x0011 -> mem_err pulses, read_data unchanged. read&write together -> mem_err, memory unchanged.
- Halt during BUSY (LAT=3): halt asserted in the 2nd cycle of a store of 0x1234 -> store completes, then halted=1. Subsequent requests are ignored and stall=0.
- Reset mid-access: rst=0 during BUSY of a store -> immediately halted=0, stall=0, read_data=0. After release, a load of that address returns 0x0000.
